// File: rtl/phase_countdown_timer.sv
// phase_countdown_timer
//   Loadable down-counter producing the remaining tick count for
//   seconds_display. A phase of N seconds lasts N*TICKS_PER_SECOND
//   cycles; done pulses once on expiry and second_tick marks each
//   whole-second boundary (the last one coincident with done).
//
//   Optional feature macro: COUNTDOWN_PAUSE_EN
//     defined     -> HOLD state built, pause freezes the countdown
//     not defined -> pause port present but ignored
//
// Ports
//   clock         in   system clock, rising edge
//   reset_n       in   asynchronous active-low reset
//   load          in   start a new phase (single-cycle strobe)
//   load_seconds  in   phase duration N in seconds, sampled with load
//   pause         in   hold the count while high (feature-dependent)
//   clock_ticks   out  remaining ticks: (seconds_left-1)*TPS + sub
//   seconds_left  out  remaining whole seconds, 0 when idle
//   second_tick   out  one-cycle strobe at each second boundary
//   busy          out  phase in progress
//   done          out  one-cycle expiry pulse
module phase_countdown_timer #(
  parameter int unsigned TICKS_PER_SECOND = 50000000,
  parameter int unsigned SECONDS_WIDTH    = 6
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     load,
  input  logic [SECONDS_WIDTH-1:0] load_seconds,
  input  logic                     pause,
  output logic [31:0]              clock_ticks,
  output logic [SECONDS_WIDTH-1:0] seconds_left,
  output logic                     second_tick,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned SUB_W =
    (TICKS_PER_SECOND > 1) ? $clog2(TICKS_PER_SECOND) : 1;
  localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(TICKS_PER_SECOND - 1);
  localparam longint unsigned MAX_TICKS =
    64'(TICKS_PER_SECOND) * ((64'd1 << SECONDS_WIDTH) - 64'd1);

  // Longest phase must fit the 32-bit tick counter.
  generate
    if (TICKS_PER_SECOND == 0 || SECONDS_WIDTH == 0 || SECONDS_WIDTH > 31 ||
        MAX_TICKS > 64'h0000_0000_FFFF_FFFF) begin : g_bad_params
      $error("phase_countdown_timer: TICKS_PER_SECOND * (2**SECONDS_WIDTH-1) overflows 32 bits");
    end
  endgenerate

`ifdef COUNTDOWN_PAUSE_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_RUN} state_t;
`endif

  state_t           r_state;
  logic [SUB_W-1:0] r_sub;

  logic [31:0] w_load_ticks;
  logic        w_load_zero;
  logic        w_count;

  assign w_load_ticks = 32'(load_seconds) * TICKS_PER_SECOND - 32'd1;
  assign w_load_zero  = (load_seconds == '0);

  // A counting step happens on every edge where the phase is active and
  // not paused; leaving HOLD counts on the same edge so a pause of P
  // cycles delays expiry by exactly P cycles.
`ifdef COUNTDOWN_PAUSE_EN
  assign w_count = ((r_state == S_RUN) || (r_state == S_HOLD)) && !pause;
`else
  logic w_unused_pause;
  assign w_unused_pause = pause;
  assign w_count        = (r_state == S_RUN);
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_sub        <= '0;
      clock_ticks  <= '0;
      seconds_left <= '0;
      second_tick  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else if (load) begin
      second_tick <= 1'b0;
      if (w_load_zero) begin
        r_state      <= S_IDLE;
        r_sub        <= '0;
        clock_ticks  <= '0;
        seconds_left <= '0;
        busy         <= 1'b0;
        done         <= 1'b1;
      end else begin
        r_state      <= S_RUN;
        r_sub        <= SUB_MAX;
        clock_ticks  <= w_load_ticks;
        seconds_left <= load_seconds;
        busy         <= 1'b1;
        done         <= 1'b0;
      end
    end else if (w_count) begin
      if (clock_ticks != '0) begin
        r_state     <= S_RUN;
        clock_ticks <= clock_ticks - 32'd1;
        done        <= 1'b0;
        if (r_sub == '0) begin
          r_sub        <= SUB_MAX;
          seconds_left <= seconds_left - SECONDS_WIDTH'(1);
          second_tick  <= 1'b1;
        end else begin
          r_sub       <= r_sub - SUB_W'(1);
          second_tick <= 1'b0;
        end
      end else begin
        r_state      <= S_IDLE;
        r_sub        <= '0;
        seconds_left <= '0;
        busy         <= 1'b0;
        done         <= 1'b1;
        second_tick  <= 1'b1;
      end
    end else begin
      second_tick <= 1'b0;
      done        <= 1'b0;
`ifdef COUNTDOWN_PAUSE_EN
      if (r_state == S_RUN) r_state <= S_HOLD;
`endif
    end
  end

endmodule

// File: tb/tb_phase_countdown_timer.sv
module tb_phase_countdown_timer;

  localparam int TPS = 10;
  localparam int SW  = 6;

  logic          clock = 1'b0;
  logic          reset_n = 1'b1;
  logic          load = 1'b0;
  logic [SW-1:0] load_seconds = '0;
  logic          pause = 1'b0;
  logic [31:0]   clock_ticks;
  logic [SW-1:0] seconds_left;
  logic          second_tick;
  logic          busy;
  logic          done;

  int errors = 0;
  int checks = 0;

  phase_countdown_timer #(
    .TICKS_PER_SECOND(TPS),
    .SECONDS_WIDTH(SW)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .load(load),
    .load_seconds(load_seconds),
    .pause(pause),
    .clock_ticks(clock_ticks),
    .seconds_left(seconds_left),
    .second_tick(second_tick),
    .busy(busy),
    .done(done)
  );

  always #5 clock = ~clock;

  // Behavioural reference: a phase is just "remaining ticks" plus an
  // active flag; seconds and the boundary strobe follow arithmetically.
  int m_ticks = 0;
  bit m_busy  = 0;
  bit m_done  = 0;
  bit m_st    = 0;

  function automatic bit counting_allowed(input logic p);
`ifdef COUNTDOWN_PAUSE_EN
    return !p;
`else
    return 1'b1;
`endif
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_ticks <= 0; m_busy <= 0; m_done <= 0; m_st <= 0;
    end else if (load) begin
      m_st <= 0;
      if (load_seconds == 0) begin
        m_ticks <= 0; m_busy <= 0; m_done <= 1;
      end else begin
        m_ticks <= int'(load_seconds) * TPS - 1; m_busy <= 1; m_done <= 0;
      end
    end else if (m_busy && counting_allowed(pause)) begin
      if (m_ticks > 0) begin
        m_ticks <= m_ticks - 1;
        m_done  <= 0;
        m_st    <= ((m_ticks - 1) / TPS) != (m_ticks / TPS);
      end else begin
        m_busy <= 0; m_done <= 1; m_st <= 1;
      end
    end else begin
      m_done <= 0; m_st <= 0;
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clock) begin
    chk("model_ticks", clock_ticks, m_ticks);
    chk("model_secs", seconds_left, m_busy ? (m_ticks / TPS + 1) : 0);
    chk("model_busy", busy, m_busy);
    chk("model_done", done, m_done);
    chk("model_tick", second_tick, m_st);
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic do_load(input int n);
    load = 1'b1;
    load_seconds = SW'(n);
    step();
    load = 1'b0;
  endtask

  task automatic wait_ticks(input int target, input string name);
    int n = 0;
    while (clock_ticks != 32'(target) && n < 1000) begin
      step();
      n++;
    end
    if (n >= 1000) chk({name, "_timeout"}, clock_ticks, target);
  endtask

  int dcount, scount, edges;

  initial begin
    #1 reset_n = 1'b0;
    #2;
    chk("rst_ticks", clock_ticks, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_secs", seconds_left, 0);
    step();
    step();
    reset_n = 1'b1;

    // N=3 phase
    do_load(3);
    chk("n3_ticks0", clock_ticks, 29);
    chk("n3_secs0", seconds_left, 3);
    chk("n3_busy0", busy, 1);
    dcount = 0; scount = 0;
    for (int k = 1; k <= 30; k++) begin
      step();
      dcount += int'(done);
      scount += int'(second_tick);
      if (k == 10) begin chk("n3_t19", clock_ticks, 19); chk("n3_st19", second_tick, 1); chk("n3_s2", seconds_left, 2); end
      if (k == 20) begin chk("n3_t9", clock_ticks, 9); chk("n3_st9", second_tick, 1); chk("n3_s1", seconds_left, 1); end
      if (k == 29) begin chk("n3_t0", clock_ticks, 0); chk("n3_nodone29", done, 0); end
      if (k == 30) begin chk("n3_done", done, 1); chk("n3_busy_end", busy, 0); chk("n3_st_end", second_tick, 1); end
    end
    chk("n3_done_count", dcount, 1);
    chk("n3_tick_count", scount, 3);
    step();
    chk("n3_done_clear", done, 0);

    // N=0 load
    do_load(0);
    chk("n0_done", done, 1);
    chk("n0_busy", busy, 0);
    chk("n0_ticks", clock_ticks, 0);
    step();
    chk("n0_done_clear", done, 0);

    // N=5 aborted by reload N=2
    do_load(5);
    wait_ticks(13, "reload");
    do_load(2);
    chk("reload_ticks", clock_ticks, 19);
    chk("reload_nodone", done, 0);
    dcount = 0;
    for (int j = 1; j <= 20; j++) begin
      step();
      dcount += int'(done);
      if (j == 20) chk("reload_done", done, 1);
    end
    chk("reload_done_count", dcount, 1);

    // pause for 7 cycles at ticks=15
    do_load(2);
    wait_ticks(15, "pause");
    pause = 1'b1;
    scount = 0;
    for (int j = 0; j < 7; j++) begin
      step();
      scount += int'(second_tick);
`ifdef COUNTDOWN_PAUSE_EN
      chk("pause_hold", clock_ticks, 15);
`endif
    end
    pause = 1'b0;
    edges = 7;
    while (!done && edges < 100) begin
      step();
      edges++;
    end
`ifdef COUNTDOWN_PAUSE_EN
    chk("pause_strobes", scount, 0);
    chk("pause_done_edges", edges, 23);
`else
    chk("nopause_done_edges", edges, 16);
`endif

    // async reset mid-phase
    do_load(1);
    wait_ticks(4, "areset");
    reset_n = 1'b0;
    #1;
    chk("arst_ticks", clock_ticks, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_secs", seconds_left, 0);
    step();
    chk("arst_nodone", done, 0);
    reset_n = 1'b1;
    do_load(1);
    chk("post_rst_load", clock_ticks, 9);

    // randomized traffic checked by the model
    for (int c = 0; c < 4000; c++) begin
      load = ($urandom_range(0, 39) == 0);
      load_seconds = ($urandom_range(0, 15) == 0) ? SW'(63) : SW'($urandom_range(0, 6));
      if ($urandom_range(0, 7) == 0) pause = ~pause;
      step();
    end
    load = 1'b0;
    pause = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
